// File: rtl/axi_mem_responder_pkg.sv
// Shared types for the cache-side AXI memory responder.
// FSM encodings live here so the bench can name them.
package mips_core_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 32;
    localparam int ID_WIDTH   = 4;
    localparam int LEN_WIDTH  = 8;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } WriteState;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_DATA
    } ReadState;

    // LEN is a direct beat count; zero still moves one beat
    function automatic logic [LEN_WIDTH-1:0] beats(
        input logic [LEN_WIDTH-1:0] len
    );
        return (len == '0) ? LEN_WIDTH'(1) : len;
    endfunction

endpackage

// File: rtl/axi_mem_responder_if.sv
// AXI subset channels between the caches and memory.
// One interface per channel, each with master/slave views.
interface axi_write_address;
    import mips_core_pkg::*;
    logic                  AWVALID;
    logic                  AWREADY;
    logic [ID_WIDTH-1:0]   AWID;
    logic [LEN_WIDTH-1:0]  AWLEN;
    logic [ADDR_WIDTH-1:0] AWADDR;
    modport master (output AWVALID, AWID, AWLEN, AWADDR,
                    input  AWREADY);
    modport slave  (input  AWVALID, AWID, AWLEN, AWADDR,
                    output AWREADY);
endinterface

interface axi_write_data;
    import mips_core_pkg::*;
    logic                  WVALID;
    logic                  WREADY;
    logic [ID_WIDTH-1:0]   WID;
    logic [DATA_WIDTH-1:0] WDATA;
    logic                  WLAST;
    modport master (output WVALID, WID, WDATA, WLAST,
                    input  WREADY);
    modport slave  (input  WVALID, WID, WDATA, WLAST,
                    output WREADY);
endinterface

interface axi_write_response;
    import mips_core_pkg::*;
    logic                BVALID;
    logic                BREADY;
    logic [ID_WIDTH-1:0] BID;
    modport master (input  BVALID, BID, output BREADY);
    modport slave  (output BVALID, BID, input  BREADY);
endinterface

interface axi_read_address;
    import mips_core_pkg::*;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [ID_WIDTH-1:0]   ARID;
    logic [LEN_WIDTH-1:0]  ARLEN;
    logic [ADDR_WIDTH-1:0] ARADDR;
    modport master (output ARVALID, ARID, ARLEN, ARADDR,
                    input  ARREADY);
    modport slave  (input  ARVALID, ARID, ARLEN, ARADDR,
                    output ARREADY);
endinterface

interface axi_read_data;
    import mips_core_pkg::*;
    logic                  RVALID;
    logic                  RREADY;
    logic [ID_WIDTH-1:0]   RID;
    logic [DATA_WIDTH-1:0] RDATA;
    logic                  RLAST;
    modport master (input  RVALID, RID, RDATA, RLAST,
                    output RREADY);
    modport slave  (output RVALID, RID, RDATA, RLAST,
                    input  RREADY);
endinterface

// File: rtl/axi_mem_responder_bank.sv
// Simple dual-port word array with a registered read port.
// A same-cycle write and read of one word returns the old word.
module cache_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_mem_responder.sv
// Slave-side AXI memory for simulation and FPGA prototypes.
// Independent read and write FSMs share one word array.
module axi_mem_responder
    import mips_core_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 12,
    parameter int READ_LATENCY   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    axi_write_address.slave   mem_write_address,
    axi_write_data.slave      mem_write_data,
    axi_write_response.slave  mem_write_response,
    axi_read_address.slave    mem_read_address,
    axi_read_data.slave       mem_read_data,
    output logic              proto_err
);

    localparam int MW    = MEM_ADDR_WIDTH;
    localparam int LAT_W = $clog2(READ_LATENCY + 1);

    WriteState             r_wstate, w_wnext;
    logic [MW-1:0]         r_widx;
    logic [LEN_WIDTH-1:0]  r_wcnt;
    logic [ID_WIDTH-1:0]   r_wid;
    logic                  r_perr;
    logic                  w_awready, w_wready, w_bvalid;
    logic                  w_we, w_wfinal;

    ReadState              r_rstate, w_rnext;
    logic [MW-1:0]         r_ridx, w_next_idx, w_raddr;
    logic [LEN_WIDTH-1:0]  r_rcnt;
    logic [ID_WIDTH-1:0]   r_rid;
    logic [LAT_W-1:0]      r_lat;
    logic                  w_arready, w_rvalid, w_rfire;
    logic [DATA_WIDTH-1:0] w_rdata;

    assign w_wfinal   = (r_wcnt == LEN_WIDTH'(1));
    assign w_next_idx = r_ridx + 1'b1;

    always_comb begin
        w_wnext   = r_wstate;
        w_awready = 1'b0;
        w_wready  = 1'b0;
        w_bvalid  = 1'b0;
        w_we      = 1'b0;
        unique case (r_wstate)
            W_IDLE: begin
                w_awready = rst_n;
                if (mem_write_address.AWVALID) w_wnext = W_DATA;
            end
            W_DATA: begin
                w_wready = rst_n;
                w_we     = rst_n & mem_write_data.WVALID;
                if (w_we && w_wfinal) w_wnext = W_RESP;
            end
            W_RESP: begin
                w_bvalid = rst_n;
                if (mem_write_response.BREADY) w_wnext = W_IDLE;
            end
            default: w_wnext = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wstate <= W_IDLE;
            r_widx   <= '0;
            r_wcnt   <= '0;
            r_wid    <= '0;
            r_perr   <= 1'b0;
        end else begin
            r_wstate <= w_wnext;
            if (w_awready && mem_write_address.AWVALID) begin
                r_widx <= mem_write_address.AWADDR[2 +: MW];
                r_wcnt <= beats(mem_write_address.AWLEN);
                r_wid  <= mem_write_address.AWID;
            end
            if (w_we) begin
                r_widx <= r_widx + 1'b1;
                r_wcnt <= r_wcnt - 1'b1;
                // the counter ends the burst; WLAST is only cross-checked
                if (mem_write_data.WLAST != w_wfinal) r_perr <= 1'b1;
            end
        end
    end

    always_comb begin
        w_rnext   = r_rstate;
        w_arready = 1'b0;
        w_rvalid  = 1'b0;
        w_rfire   = 1'b0;
        w_raddr   = r_ridx;
        unique case (r_rstate)
            R_IDLE: begin
                w_arready = rst_n;
                w_raddr   = mem_read_address.ARADDR[2 +: MW];
                if (mem_read_address.ARVALID)
                    w_rnext = (READ_LATENCY == 1) ? R_DATA : R_WAIT;
            end
            R_WAIT: begin
                if (r_lat == LAT_W'(1)) w_rnext = R_DATA;
            end
            R_DATA: begin
                w_rvalid = rst_n;
                w_rfire  = w_rvalid & mem_read_data.RREADY;
                // prefetch so RDATA is ready the cycle after a handshake
                w_raddr  = w_rfire ? w_next_idx : r_ridx;
                if (w_rfire && r_rcnt == LEN_WIDTH'(1)) w_rnext = R_IDLE;
            end
            default: w_rnext = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rstate <= R_IDLE;
            r_ridx   <= '0;
            r_rcnt   <= '0;
            r_rid    <= '0;
            r_lat    <= '0;
        end else begin
            r_rstate <= w_rnext;
            if (w_arready && mem_read_address.ARVALID) begin
                r_ridx <= mem_read_address.ARADDR[2 +: MW];
                r_rcnt <= beats(mem_read_address.ARLEN);
                r_rid  <= mem_read_address.ARID;
                r_lat  <= LAT_W'(READ_LATENCY - 1);
            end
            if (r_rstate == R_WAIT) r_lat <= r_lat - 1'b1;
            if (w_rfire) begin
                r_ridx <= w_next_idx;
                r_rcnt <= r_rcnt - 1'b1;
            end
        end
    end

    cache_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (MW)
    ) u_bank (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_widx),
        .i_wdata (mem_write_data.WDATA),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    assign mem_write_address.AWREADY = w_awready;
    assign mem_write_data.WREADY     = w_wready;
    assign mem_write_response.BVALID = w_bvalid;
    assign mem_write_response.BID    = r_wid;
    assign mem_read_address.ARREADY  = w_arready;
    assign mem_read_data.RVALID      = w_rvalid;
    assign mem_read_data.RID         = r_rid;
    assign mem_read_data.RDATA       = w_rdata;
    assign mem_read_data.RLAST       = w_rvalid & (r_rcnt == LEN_WIDTH'(1));
    assign proto_err                 = r_perr;

    logic w_unused;
    assign w_unused = &{1'b0, mem_write_address.AWADDR,
                        mem_read_address.ARADDR, mem_write_data.WID};

endmodule

// File: tb/tb_axi_mem_responder.sv
// Scenario bench for axi_mem_responder with a reference word model
// and a queue of expected read beats.
module tb_axi_mem_responder;
    import mips_core_pkg::*;

    localparam int MAW = 12;
    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic perr;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axi_write_address  aw();
    axi_write_data     wd();
    axi_write_response wr();
    axi_read_address   ar();
    axi_read_data      rd();

    axi_mem_responder #(
        .MEM_ADDR_WIDTH (MAW),
        .READ_LATENCY   (LAT)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .mem_write_address  (aw),
        .mem_write_data     (wd),
        .mem_write_response (wr),
        .mem_read_address   (ar),
        .mem_read_data      (rd),
        .proto_err          (perr)
    );

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] model [0:4095];
    logic [31:0] exp_q [$];
    logic [31:0] wbuf [0:7];
    logic        exp_err = 1'b0;

    task automatic write_burst(input logic [31:0] addr, input int n,
                               input int lastbeat, input logic [3:0] id,
                               input int bstall);
        int g;
        int nb;
        logic [11:0] idx;
        logic [11:0] wi;
        nb = (n == 0) ? 1 : n;
        idx = addr[13:2];
        aw.AWVALID = 1'b1;
        aw.AWADDR = addr;
        aw.AWLEN = 8'(n);
        aw.AWID = id;
        g = 0;
        while (aw.AWREADY !== 1'b1 && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) begin
            vectors++; miscompares++;
            $display("FAIL aw_timeout addr=%h", addr);
            aw.AWVALID = 1'b0;
            return;
        end
        @(negedge clk);
        aw.AWVALID = 1'b0;
        vectors++;
        if (wd.WREADY !== 1'b1) begin
            miscompares++;
            $display("FAIL wready_after_aw got=%b exp=1", wd.WREADY);
        end
        for (int i = 0; i < nb; i++) begin
            vectors++;
            if (wd.WREADY !== 1'b1 || wr.BVALID !== 1'b0) begin
                miscompares++;
                $display("FAIL w_beat%0d wready=%b bvalid=%b exp 1/0",
                         i, wd.WREADY, wr.BVALID);
            end
            wd.WVALID = 1'b1;
            wd.WDATA = wbuf[i];
            wd.WLAST = (i == lastbeat);
            wd.WID = id;
            wi = idx + 12'(i);
            model[wi] = wbuf[i];
            if ((i == lastbeat) != (i == nb - 1)) exp_err = 1'b1;
            @(negedge clk);
            vectors++;
            if (perr !== exp_err) begin
                miscompares++;
                $display("FAIL proto_err beat%0d got=%b exp=%b",
                         i, perr, exp_err);
            end
        end
        wd.WVALID = 1'b0;
        wd.WLAST = 1'b0;
        vectors++;
        if (wr.BVALID !== 1'b1 || wr.BID !== id) begin
            miscompares++;
            $display("FAIL b_resp bvalid=%b bid=%h exp 1/%h",
                     wr.BVALID, wr.BID, id);
        end
        for (int k = 0; k < bstall; k++) begin
            vectors++;
            if (wr.BVALID !== 1'b1 || aw.AWREADY !== 1'b0) begin
                miscompares++;
                $display("FAIL b_hold%0d bvalid=%b awready=%b exp 1/0",
                         k, wr.BVALID, aw.AWREADY);
            end
            @(negedge clk);
        end
        wr.BREADY = 1'b1;
        @(negedge clk);
        wr.BREADY = 1'b0;
        vectors++;
        if (wr.BVALID !== 1'b0 || aw.AWREADY !== 1'b1) begin
            miscompares++;
            $display("FAIL after_b bvalid=%b awready=%b exp 0/1",
                     wr.BVALID, aw.AWREADY);
        end
    endtask

    task automatic read_burst(input logic [31:0] addr, input int n,
                              input logic [3:0] id, input int stall_at,
                              input int stall_len);
        int g;
        int t;
        int nb;
        int beat;
        logic [11:0] idx;
        logic [11:0] ri;
        nb = (n == 0) ? 1 : n;
        idx = addr[13:2];
        ar.ARVALID = 1'b1;
        ar.ARADDR = addr;
        ar.ARLEN = 8'(n);
        ar.ARID = id;
        g = 0;
        while (ar.ARREADY !== 1'b1 && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) begin
            vectors++; miscompares++;
            $display("FAIL ar_timeout addr=%h", addr);
            ar.ARVALID = 1'b0;
            return;
        end
        t = cyc;
        for (int i = 0; i < nb; i++) begin
            ri = idx + 12'(i);
            exp_q.push_back(model[ri]);
        end
        @(negedge clk);
        ar.ARVALID = 1'b0;
        rd.RREADY = 1'b1;
        g = 0;
        while (rd.RVALID !== 1'b1 && g < 50) begin
            @(negedge clk);
            g++;
        end
        vectors++;
        if (cyc - t !== LAT) begin
            miscompares++;
            $display("FAIL r_latency got=%0d exp=%0d", cyc - t, LAT);
        end
        beat = 0;
        g = 0;
        while (beat < nb && g < 100) begin
            g++;
            if (rd.RVALID !== 1'b1) begin
                vectors++; miscompares++;
                $display("FAIL r_gap beat%0d rvalid=%b exp=1",
                         beat, rd.RVALID);
                @(negedge clk);
                continue;
            end
            if (beat == stall_at && stall_len > 0) begin
                rd.RREADY = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clk);
                    vectors++;
                    if (rd.RVALID !== 1'b1 || rd.RDATA !== exp_q[0]) begin
                        miscompares++;
                        $display("FAIL r_stall%0d rvalid=%b rdata=%h exp 1/%h",
                                 s, rd.RVALID, rd.RDATA, exp_q[0]);
                    end
                end
                rd.RREADY = 1'b1;
                stall_len = 0;
            end
            vectors++;
            if (rd.RDATA !== exp_q[0] || rd.RID !== id ||
                rd.RLAST !== (beat == nb - 1)) begin
                miscompares++;
                $display("FAIL r_beat%0d rdata=%h rid=%h rlast=%b exp %h/%h/%b",
                         beat, rd.RDATA, rd.RID, rd.RLAST, exp_q[0], id,
                         (beat == nb - 1));
            end
            void'(exp_q.pop_front());
            if (beat == nb - 1 && stall_at >= nb) begin
                vectors++;
                if (cyc - t !== LAT + nb - 1) begin
                    miscompares++;
                    $display("FAIL r_last_time got=%0d exp=%0d",
                             cyc - t, LAT + nb - 1);
                end
            end
            beat++;
            @(negedge clk);
        end
        if (beat < nb) begin
            vectors++; miscompares++;
            $display("FAIL r_timeout beats=%0d exp=%0d", beat, nb);
        end
        rd.RREADY = 1'b0;
        exp_q.delete();
        vectors++;
        if (rd.RVALID !== 1'b0 || ar.ARREADY !== 1'b1) begin
            miscompares++;
            $display("FAIL after_r rvalid=%b arready=%b exp 0/1",
                     rd.RVALID, ar.ARREADY);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (aw.AWREADY !== 1'b0 || ar.ARREADY !== 1'b0 ||
            wd.WREADY !== 1'b0 || wr.BVALID !== 1'b0 ||
            rd.RVALID !== 1'b0 || perr !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs aw=%b ar=%b w=%b b=%b r=%b pe=%b exp all 0",
                     aw.AWREADY, ar.ARREADY, wd.WREADY, wr.BVALID,
                     rd.RVALID, perr);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (aw.AWREADY !== 1'b1 || ar.ARREADY !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release awready=%b arready=%b exp 1/1",
                     aw.AWREADY, ar.ARREADY);
        end
    endtask

    task automatic test_write_then_read();
        wbuf[0] = 32'h11; wbuf[1] = 32'h22;
        wbuf[2] = 32'h33; wbuf[3] = 32'h44;
        write_burst(32'h40, 4, 3, 4'h0, 0);
        read_burst(32'h40, 4, 4'h1, 99, 0);
        read_burst(32'h40, 0, 4'h3, 99, 0);
    endtask

    task automatic test_read_backpressure();
        for (int i = 0; i < 8; i++) wbuf[i] = 32'hA000_0000 + 32'(i * 7);
        write_burst(32'h200, 6, 5, 4'h2, 0);
        read_burst(32'h200, 6, 4'h3, 2, 3);
    endtask

    task automatic test_b_backpressure();
        wbuf[0] = 32'hDEAD_BEEF; wbuf[1] = 32'hCAFE_F00D;
        write_burst(32'h300, 2, 1, 4'h5, 5);
        read_burst(32'h300, 2, 4'h6, 99, 0);
    endtask

    task automatic test_concurrent_wrap();
        wbuf[0] = 32'h0FFE_0001; wbuf[1] = 32'h0FFF_0002;
        wbuf[2] = 32'h0000_0003; wbuf[3] = 32'h0001_0004;
        write_burst(32'h3FF8, 4, 3, 4'h1, 0);
        read_burst(32'h0, 2, 4'h2, 99, 0);
        wbuf[0] = 32'h5555_0000; wbuf[1] = 32'h5555_1111;
        wbuf[2] = 32'h5555_2222; wbuf[3] = 32'h5555_3333;
        fork
            write_burst(32'h100, 4, 3, 4'h6, 2);
            begin
                @(negedge clk);
                read_burst(32'h3FF8, 4, 4'h7, 99, 0);
            end
        join
        read_burst(32'h100, 4, 4'h8, 99, 0);
    endtask

    task automatic test_proto_err();
        vectors++;
        if (perr !== 1'b0) begin
            miscompares++;
            $display("FAIL proto_pre got=%b exp=0", perr);
        end
        wbuf[0] = 32'h1; wbuf[1] = 32'h2; wbuf[2] = 32'h3; wbuf[3] = 32'h4;
        write_burst(32'h500, 4, 1, 4'h9, 0);
        read_burst(32'h500, 4, 4'hA, 99, 0);
        vectors++;
        if (perr !== 1'b1) begin
            miscompares++;
            $display("FAIL proto_sticky got=%b exp=1", perr);
        end
    endtask

    task automatic test_reset_mid_burst();
        int g;
        ar.ARVALID = 1'b1;
        ar.ARADDR = 32'h40;
        ar.ARLEN = 8'd4;
        ar.ARID = 4'hB;
        g = 0;
        while (ar.ARREADY !== 1'b1 && g < 50) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        ar.ARVALID = 1'b0;
        rd.RREADY = 1'b1;
        g = 0;
        while (rd.RVALID !== 1'b1 && g < 50) begin
            @(negedge clk);
            g++;
        end
        vectors++;
        if (rd.RVALID !== 1'b1 || rd.RDATA !== model[12'h010]) begin
            miscompares++;
            $display("FAIL rst_mid_first rvalid=%b rdata=%h exp 1/%h",
                     rd.RVALID, rd.RDATA, model[12'h010]);
        end
        @(negedge clk);
        rd.RREADY = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if (rd.RVALID !== 1'b0 || ar.ARREADY !== 1'b0 ||
            aw.AWREADY !== 1'b0 || wr.BVALID !== 1'b0 || perr !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_outputs r=%b ar=%b aw=%b b=%b pe=%b exp all 0",
                     rd.RVALID, ar.ARREADY, aw.AWREADY, wr.BVALID, perr);
        end
        rst_n = 1'b1;
        exp_err = 1'b0;
        @(negedge clk);
        vectors++;
        if (ar.ARREADY !== 1'b1 || rd.RVALID !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_release arready=%b rvalid=%b exp 1/0",
                     ar.ARREADY, rd.RVALID);
        end
        read_burst(32'h40, 4, 4'hC, 99, 0);
    endtask

    initial begin
        aw.AWVALID = 1'b0; aw.AWADDR = '0; aw.AWLEN = '0; aw.AWID = '0;
        wd.WVALID = 1'b0; wd.WDATA = '0; wd.WLAST = 1'b0; wd.WID = '0;
        wr.BREADY = 1'b0;
        ar.ARVALID = 1'b0; ar.ARADDR = '0; ar.ARLEN = '0; ar.ARID = '0;
        rd.RREADY = 1'b0;
        @(negedge clk);
        test_reset();
        test_write_then_read();
        test_read_backpressure();
        test_b_backpressure();
        test_concurrent_wrap();
        test_proto_err();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
